// File: rtl/bubble_pkg.sv
// bubble_pkg: shared state encoding, default sizes and direction constants for the bubble slot manager
package bubble_pkg;
  localparam int NUM_SLOTS = 8;
  localparam int SIZE_W = 2;
  localparam int INIT_SIZE = 3;
  localparam logic DIR_LEFT = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
  typedef enum logic [2:0] {
    IDLE,
    INIT,
    ARMED,
    KILL,
    SPAWN_A,
    SPAWN_B,
    CHECK,
    CLEAR
  } state_t;
endpackage

// File: rtl/lowest_free_slot.sv
// lowest_free_slot: priority encoder returning the lowest-index clear bit of the occupancy mask
module lowest_free_slot #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] alive,
  output logic [W-1:0] idx,
  output logic         found
);
  // scan from the top so the lowest free index is the last one written
  always_comb begin
    idx = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!alive[i]) begin
        idx = W'(i);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/bubble_slot_manager.sv
// bubble_slot_manager: seeds a level, splits hit bubbles into free slots and reports level clear
module bubble_slot_manager
  import bubble_pkg::*;
#(
  parameter int NUM_SLOTS = bubble_pkg::NUM_SLOTS,
  parameter int SLOT_W = $clog2(NUM_SLOTS),
  parameter int SIZE_W = bubble_pkg::SIZE_W,
  parameter int INIT_SIZE = bubble_pkg::INIT_SIZE
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 start,
  input  logic                 freeze,
  input  logic                 hit_valid,
  input  logic [SLOT_W-1:0]    hit_slot,
  output logic                 hit_ready,
  output logic                 spawn_valid,
  output logic [SLOT_W-1:0]    spawn_slot,
  output logic [SIZE_W-1:0]    spawn_size,
  output logic                 spawn_dir,
  output logic                 kill_valid,
  output logic [SLOT_W-1:0]    kill_slot,
  output logic [SIZE_W-1:0]    pop_size,
  output logic [NUM_SLOTS-1:0] alive,
  output logic                 level_clear,
  output logic                 overflow,
  output logic                 busy
);
  state_t state, state_d;
  logic [SIZE_W-1:0] sizes [NUM_SLOTS];
  logic [SLOT_W-1:0] h_slot, free_slot, spawn_at;
  logic [SIZE_W-1:0] h_size, spawn_sz;
  logic accept, found, spawn_en, spawn_d, kill_en, clear_en, ovf_set;

  assign hit_ready = (state == ARMED) && !freeze;
  assign accept = hit_valid && hit_ready;

  lowest_free_slot #(.N(NUM_SLOTS), .W(SLOT_W)) u_free (
    .alive(alive),
    .idx(free_slot),
    .found(found)
  );

  // state register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else state <= state_d;
  end

  // next-state: start overrides everything, a split runs to completion regardless of freeze
  always_comb begin
    state_d = state;
    if (start) state_d = INIT;
    else begin
      case (state)
        INIT:    state_d = ARMED;
        ARMED:   state_d = (accept && alive[hit_slot]) ? KILL : ARMED;
        KILL:    state_d = (h_size == '0) ? CHECK : SPAWN_A;
        SPAWN_A: state_d = SPAWN_B;
        SPAWN_B: state_d = ARMED;
        CHECK:   state_d = (alive == '0) ? CLEAR : ARMED;
        default: state_d = state;
      endcase
    end
  end

  // command decode for the edge leaving the current state; child size is only formed when size > 0
  always_comb begin
    spawn_en = 1'b0;
    spawn_at = '0;
    spawn_d = DIR_RIGHT;
    spawn_sz = SIZE_W'(INIT_SIZE);
    kill_en = 1'b0;
    clear_en = 1'b0;
    ovf_set = 1'b0;
    if (start) spawn_en = 1'b1;
    else begin
      case (state)
        ARMED: kill_en = accept && alive[hit_slot];
        KILL: begin
          spawn_en = h_size != '0;
          spawn_at = h_slot;
          spawn_d = DIR_LEFT;
          spawn_sz = (h_size != '0) ? h_size - SIZE_W'(1) : '0;
        end
        SPAWN_A: begin
          spawn_en = found;
          spawn_at = free_slot;
          spawn_sz = h_size - SIZE_W'(1);
          ovf_set = !found;
        end
        CHECK: clear_en = alive == '0;
        default: spawn_en = 1'b0;
      endcase
    end
  end

  // registered commands, occupancy, per-slot sizes and the latched hit
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      spawn_valid <= 1'b0;
      spawn_slot <= '0;
      spawn_size <= '0;
      spawn_dir <= 1'b0;
      kill_valid <= 1'b0;
      kill_slot <= '0;
      pop_size <= '0;
      alive <= '0;
      level_clear <= 1'b0;
      overflow <= 1'b0;
      busy <= 1'b1;
      h_slot <= '0;
      h_size <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) sizes[i] <= '0;
    end else begin
      spawn_valid <= spawn_en;
      kill_valid <= kill_en;
      level_clear <= clear_en;
      busy <= (state_d != ARMED) && (state_d != CLEAR);
      if (start) begin
        alive <= NUM_SLOTS'(1);
        overflow <= 1'b0;
      end else begin
        if (kill_en) alive[hit_slot] <= 1'b0;
        if (spawn_en) alive[spawn_at] <= 1'b1;
        if (ovf_set) overflow <= 1'b1;
      end
      if (spawn_en) begin
        spawn_slot <= spawn_at;
        spawn_size <= spawn_sz;
        spawn_dir <= spawn_d;
        sizes[spawn_at] <= spawn_sz;
      end
      if (kill_en) begin
        kill_slot <= hit_slot;
        pop_size <= sizes[hit_slot];
      end
      if (accept) begin
        h_slot <= hit_slot;
        h_size <= sizes[hit_slot];
      end
    end
  end
endmodule

// File: tb/tb_bubble_slot_manager.sv
// tb_bubble_slot_manager: directed checks of seeding, splitting, freeze, overflow, restart and level clear
module tb_bubble_slot_manager;
  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic start = 1'b0, freeze = 1'b0, hit_valid = 1'b0;
  logic [2:0] hit_slot = '0;
  logic hit_ready, spawn_valid, spawn_dir, kill_valid, level_clear, overflow, busy;
  logic [2:0] spawn_slot, kill_slot;
  logic [1:0] spawn_size, pop_size;
  logic [7:0] alive;
  logic start_b = 1'b0, hit_valid_b = 1'b0;
  logic [0:0] hit_slot_b = '0;
  logic hit_ready_b, spawn_valid_b, spawn_dir_b, kill_valid_b, level_clear_b, overflow_b, busy_b;
  logic [0:0] spawn_slot_b, kill_slot_b;
  logic [1:0] spawn_size_b, pop_size_b, alive_b;
  int vectors = 0, errors = 0;
  int kills = 0, clears = 0, pop_sum = 0;
  int k0, c0, p0, sel, kf;

  always #5 clk = ~clk;

  bubble_slot_manager dut (
    .clk(clk), .resetN(resetN), .start(start), .freeze(freeze),
    .hit_valid(hit_valid), .hit_slot(hit_slot), .hit_ready(hit_ready),
    .spawn_valid(spawn_valid), .spawn_slot(spawn_slot), .spawn_size(spawn_size), .spawn_dir(spawn_dir),
    .kill_valid(kill_valid), .kill_slot(kill_slot), .pop_size(pop_size), .alive(alive),
    .level_clear(level_clear), .overflow(overflow), .busy(busy)
  );

  bubble_slot_manager #(.NUM_SLOTS(2), .INIT_SIZE(3)) dut_b (
    .clk(clk), .resetN(resetN), .start(start_b), .freeze(freeze),
    .hit_valid(hit_valid_b), .hit_slot(hit_slot_b), .hit_ready(hit_ready_b),
    .spawn_valid(spawn_valid_b), .spawn_slot(spawn_slot_b), .spawn_size(spawn_size_b), .spawn_dir(spawn_dir_b),
    .kill_valid(kill_valid_b), .kill_slot(kill_slot_b), .pop_size(pop_size_b), .alive(alive_b),
    .level_clear(level_clear_b), .overflow(overflow_b), .busy(busy_b)
  );

  // pulse counters for the main instance, sampled mid-cycle
  always @(negedge clk) begin
    if (kill_valid) begin
      kills <= kills + 1;
      pop_sum <= pop_sum + int'(pop_size);
    end
    if (level_clear) clears <= clears + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) cyc();
    check("rst_alive", 32'(alive), 0);
    check("rst_spawn", 32'(spawn_valid), 0);
    check("rst_kill", 32'(kill_valid), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_ready", 32'(hit_ready), 0);
    check("rst_clear", 32'(level_clear), 0);
    resetN = 1'b1;
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("init_spawn", {spawn_valid, 1'b0, spawn_slot, 2'b0, spawn_size, 3'b0, spawn_dir}, 32'h1_0_3_1);
    check("init_alive", 32'(alive), 32'h01);
    cyc();
    check("armed_ready", 32'(hit_ready), 1);
    check("armed_busy", 32'(busy), 0);
    hit_valid = 1'b1;
    hit_slot = 3'd0;
    cyc();
    hit_valid = 1'b0;
    check("h0_kill", {kill_valid, 1'b0, kill_slot, 2'b0, pop_size}, 32'h1_0_3);
    check("h0_kill_alive", 32'(alive), 32'h00);
    check("h0_kill_ready", 32'(hit_ready), 0);
    cyc();
    check("h0_spawn_a", {spawn_valid, 1'b0, spawn_slot, 2'b0, spawn_size, 3'b0, spawn_dir}, 32'h1_0_2_0);
    cyc();
    check("h0_spawn_b", {spawn_valid, 1'b0, spawn_slot, 2'b0, spawn_size, 3'b0, spawn_dir}, 32'h1_1_2_1);
    check("h0_b_ready", 32'(hit_ready), 0);
    cyc();
    check("h0_alive", 32'(alive), 32'h03);
    check("h0_ready4", 32'(hit_ready), 1);
    hit_valid = 1'b1;
    hit_slot = 3'd5;
    cyc();
    hit_valid = 1'b0;
    check("dead_kill", {kill_valid, spawn_valid}, 0);
    check("dead_alive", 32'(alive), 32'h03);
    check("dead_ready", 32'(hit_ready), 1);
    freeze = 1'b1;
    hit_valid = 1'b1;
    hit_slot = 3'd0;
    kf = kills;
    repeat (10) cyc();
    check("frz_kills", 32'(kills - kf), 0);
    check("frz_ready", 32'(hit_ready), 0);
    check("frz_alive", 32'(alive), 32'h03);
    freeze = 1'b0;
    #1;
    check("unfrz_ready", 32'(hit_ready), 1);
    cyc();
    hit_valid = 1'b0;
    check("unfrz_kill", {kill_valid, 1'b0, kill_slot, 2'b0, pop_size}, 32'h1_0_2);
    cyc();
    cyc();
    check("unfrz_spawn_b", {spawn_valid, 1'b0, spawn_slot, 2'b0, spawn_size, 3'b0, spawn_dir}, 32'h1_2_1_1);
    cyc();
    check("unfrz_alive", 32'(alive), 32'h07);
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    k0 = kills;
    c0 = clears;
    p0 = pop_sum;
    for (int n = 0; n < 15; n++) begin
      sel = 0;
      for (int i = 7; i >= 0; i--) if (alive[i]) sel = i;
      hit_valid = 1'b1;
      hit_slot = 3'(sel);
      cyc();
      hit_valid = 1'b0;
      for (int w = 0; w < 10 && busy; w++) cyc();
    end
    cyc();
    check("pop_settle", 32'(busy), 0);
    check("pop_kills", 32'(kills - k0), 15);
    check("pop_sizesum", 32'(pop_sum - p0), 11);
    check("pop_clears", 32'(clears - c0), 1);
    check("pop_ovf", 32'(overflow), 0);
    check("pop_alive", 32'(alive), 0);
    check("clear_ready", 32'(hit_ready), 0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    hit_valid = 1'b1;
    hit_slot = 3'd0;
    cyc();
    hit_valid = 1'b0;
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("abort_spawn", {spawn_valid, 1'b0, spawn_slot, 2'b0, spawn_size, 3'b0, spawn_dir}, 32'h1_0_3_1);
    check("abort_alive", 32'(alive), 32'h01);
    cyc();
    check("abort_nob", 32'(spawn_valid), 0);
    check("abort_alive2", 32'(alive), 32'h01);
    start_b = 1'b1;
    cyc();
    start_b = 1'b0;
    cyc();
    hit_valid_b = 1'b1;
    hit_slot_b = 1'b0;
    cyc();
    hit_valid_b = 1'b0;
    repeat (3) cyc();
    check("b_alive1", 32'(alive_b), 32'h3);
    check("b_ready1", 32'(hit_ready_b), 1);
    hit_valid_b = 1'b1;
    hit_slot_b = 1'b1;
    cyc();
    hit_valid_b = 1'b0;
    check("b_kill", {kill_valid_b, 3'b0, kill_slot_b, 2'b0, pop_size_b}, 32'h1_1_2);
    cyc();
    cyc();
    check("b_no_spawn", 32'(spawn_valid_b), 0);
    check("b_ovf", 32'(overflow_b), 1);
    cyc();
    check("b_alive2", 32'(alive_b), 32'h3);
    start_b = 1'b1;
    cyc();
    start_b = 1'b0;
    check("b_ovf_clr", 32'(overflow_b), 0);
    check("b_alive3", 32'(alive_b), 32'h1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
